// File: rtl/exe_pkg.sv
// exe_pkg: shared definitions for the execute stage.
//   - default width constants for the stage parameters
//   - 6-bit ALU opcode encodings
//   - multiply/divide FSM state enum
//   - helper telling signed from unsigned multiply/divide opcodes
package exe_pkg;

  localparam int DEFAULT_DATA_W  = 32;
  localparam int DEFAULT_NUM_FWD = 3;
  localparam int DEFAULT_SEL_W   = 2;

  localparam logic [5:0] OP_SLL   = 6'h00, OP_SRL  = 6'h02, OP_SRA   = 6'h03,
                         OP_MFHI  = 6'h10, OP_MTHI = 6'h11, OP_MFLO  = 6'h12,
                         OP_MTLO  = 6'h13, OP_MULT = 6'h18, OP_MULTU = 6'h19,
                         OP_DIV   = 6'h1A, OP_DIVU = 6'h1B, OP_ADD   = 6'h20,
                         OP_ADDU  = 6'h21, OP_SUB  = 6'h22, OP_SUBU  = 6'h23,
                         OP_AND   = 6'h24, OP_OR   = 6'h25, OP_XOR   = 6'h26,
                         OP_NOR   = 6'h27, OP_SLT  = 6'h2A, OP_SLTU  = 6'h2B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } md_state_e;

  // MULT/DIV are even opcodes, their unsigned twins are odd.
  function automatic logic isSignedMd(input logic [5:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/exe_alu.sv
// exe_alu: combinational single-cycle ALU of the execute stage.
// Ports:
//   a_i, b_i   resolved operands (shifts act on b_i)
//   shamt_i    shift amount
//   op_i       6-bit opcode (see exe_pkg)
//   hi_i, lo_i current HI/LO, returned by MFHI/MFLO
//   result_o   result; zero for opcodes with no single-cycle result
module exe_alu
  import exe_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [4:0]        shamt_i,
  input  logic [5:0]        op_i,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  output logic [DATA_W-1:0] result_o
);

  // Arithmetic wraps silently; there are no overflow traps.
  always_comb begin
    result_o = '0;
    case (op_i)
      OP_SLL:            result_o = b_i << shamt_i;
      OP_SRL:            result_o = b_i >> shamt_i;
      OP_SRA:            result_o = $signed(b_i) >>> shamt_i;
      OP_MFHI:           result_o = hi_i;
      OP_MFLO:           result_o = lo_i;
      OP_ADD, OP_ADDU:   result_o = a_i + b_i;
      OP_SUB, OP_SUBU:   result_o = a_i - b_i;
      OP_AND:            result_o = a_i & b_i;
      OP_OR:             result_o = a_i | b_i;
      OP_XOR:            result_o = a_i ^ b_i;
      OP_NOR:            result_o = ~(a_i | b_i);
      OP_SLT:            result_o = {{(DATA_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OP_SLTU:           result_o = {{(DATA_W-1){1'b0}}, (a_i < b_i)};
      default:           result_o = '0;
    endcase
  end

endmodule

// File: rtl/exe_stage_mc.sv
// exe_stage_mc: execute stage between decode/issue and MEM.
//   - operand select muxes over NUM_FWD bypass slots
//   - valid/ready handshake towards issue (in_*) and MEM (out_*)
//   - iterative multiply (shift-add) / restoring divide FSM owning HI/LO
//   - synchronous Flush, asynchronous active-low RESET
// Ports: CLK, RESET, Flush; in_valid/in_ready and the *_IN instruction
// fields; out_valid/out_ready and the registered *_OUT fields;
// ALU_result_forward (combinational), HI_OUT/LO_OUT, busy.
// Build option: define EXE_FAST_MUL_EN to make MULT/MULTU single-cycle
// through a full multiplier; divide stays iterative either way.
module exe_stage_mc
  import exe_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int NUM_FWD = DEFAULT_NUM_FWD,
  parameter int SEL_W   = DEFAULT_SEL_W
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      Flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               Instr_IN,
  input  logic [31:0]               Instr_PC_IN,
  input  logic [DATA_W-1:0]         OperandA_IN,
  input  logic [DATA_W-1:0]         OperandB_IN,
  input  logic [SEL_W-1:0]          RegA_Select,
  input  logic [SEL_W-1:0]          RegB_Select,
  input  logic [NUM_FWD*DATA_W-1:0] Fwd_Data_IN,
  input  logic [4:0]                WriteRegister_IN,
  input  logic                      RegWrite_IN,
  input  logic                      MemRead_IN,
  input  logic                      MemWrite_IN,
  input  logic [DATA_W-1:0]         MemWriteData_IN,
  input  logic [5:0]                ALU_Control_IN,
  input  logic [4:0]                ShiftAmount_IN,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               Instr_OUT,
  output logic [31:0]               Instr_PC_OUT,
  output logic [DATA_W-1:0]         ALU_result_OUT,
  output logic [4:0]                WriteRegister_OUT,
  output logic [DATA_W-1:0]         MemWriteData_OUT,
  output logic                      RegWrite_OUT,
  output logic [5:0]                ALU_Control_OUT,
  output logic                      MemRead_OUT,
  output logic                      MemWrite_OUT,
  output logic [DATA_W-1:0]         ALU_result_forward,
  output logic [DATA_W-1:0]         HI_OUT,
  output logic [DATA_W-1:0]         LO_OUT,
  output logic                      busy
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  md_state_e           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   accHi_q, accHi_d, accLo_q, accLo_d, opMag_q, opMag_d;
  logic [DATA_W-1:0]   dividend_q, dividend_d;
  logic                resNeg_q, resNeg_d, remNeg_q, remNeg_d, divZero_q, divZero_d;
  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic                outValid_q, outValid_d;
  logic [31:0]         instr_q, instr_d, pc_q, pc_d;
  logic [DATA_W-1:0]   aluRes_q, aluRes_d, memData_q, memData_d;
  logic [4:0]          wreg_q, wreg_d;
  logic [5:0]          aluCtl_q, aluCtl_d;
  logic                regWrite_q, regWrite_d, memRead_q, memRead_d, memWrite_q, memWrite_d;

  logic [DATA_W-1:0]   opA, opB, magA, magB, aluResult;
  logic                signA, signB, accept, isMultOp, isDivOp, startsLong, fastMul, lastIter;
  logic [2*DATA_W-1:0] fastProd;

  // A select of k picks bypass slot k-1; zero or any unused code falls
  // back to the register-file operand.
  always_comb begin
    opA = OperandA_IN;
    opB = OperandB_IN;
    for (int j = 0; j < NUM_FWD; j++) begin
      if (RegA_Select == SEL_W'(j + 1)) opA = Fwd_Data_IN[j*DATA_W +: DATA_W];
      if (RegB_Select == SEL_W'(j + 1)) opB = Fwd_Data_IN[j*DATA_W +: DATA_W];
    end
  end

  exe_alu #(.DATA_W(DATA_W)) u_alu (
    .a_i      (opA),
    .b_i      (opB),
    .shamt_i  (ShiftAmount_IN),
    .op_i     (ALU_Control_IN),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .result_o (aluResult)
  );

  assign isMultOp = (ALU_Control_IN == OP_MULT) || (ALU_Control_IN == OP_MULTU);
  assign isDivOp  = (ALU_Control_IN == OP_DIV)  || (ALU_Control_IN == OP_DIVU);
  assign signA    = isSignedMd(ALU_Control_IN) & opA[DATA_W-1];
  assign signB    = isSignedMd(ALU_Control_IN) & opB[DATA_W-1];
  assign magA     = signA ? -opA : opA;
  assign magB     = signB ? -opB : opB;

`ifdef EXE_FAST_MUL_EN
  logic [2*DATA_W-1:0] fastMag;
  assign fastMag    = {{DATA_W{1'b0}}, magA} * {{DATA_W{1'b0}}, magB};
  assign fastProd   = (signA ^ signB) ? -fastMag : fastMag;
  assign fastMul    = isMultOp;
  assign startsLong = isDivOp;
`else
  assign fastProd   = '0;
  assign fastMul    = 1'b0;
  assign startsLong = isMultOp | isDivOp;
`endif

  assign busy               = (state_q != IDLE);
  assign in_ready           = !busy && (!outValid_q || out_ready);
  assign accept             = in_valid && in_ready && !Flush;
  assign lastIter           = busy && (cnt_q == CNT_W'(DATA_W - 1));
  assign ALU_result_forward = fastMul ? fastProd[DATA_W-1:0] : aluResult;

  // One iteration of each long operation. The multiply keeps the partial
  // product in accHi and shifts the multiplier out of accLo; the divide
  // keeps the remainder in accHi and shifts quotient bits into accLo.
  logic [DATA_W:0]     mulSum, divShift, divTrial;
  logic                divFits;
  logic [DATA_W-1:0]   stepHi, stepLo, quoFix, remFix, doneHi, doneLo;
  logic [2*DATA_W-1:0] prodFix;

  always_comb begin
    mulSum   = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, opMag_q} : {(DATA_W+1){1'b0}});
    divShift = {accHi_q, accLo_q[DATA_W-1]};
    divTrial = divShift - {1'b0, opMag_q};
    divFits  = !divTrial[DATA_W];
    if (state_q == MUL) begin
      stepHi = mulSum[DATA_W:1];
      stepLo = {mulSum[0], accLo_q[DATA_W-1:1]};
    end else begin
      stepHi = divFits ? divTrial[DATA_W-1:0] : divShift[DATA_W-1:0];
      stepLo = {accLo_q[DATA_W-2:0], divFits};
    end
    prodFix = resNeg_q ? -{stepHi, stepLo} : {stepHi, stepLo};
    quoFix  = resNeg_q ? -stepLo : stepLo;
    remFix  = remNeg_q ? -stepHi : stepHi;
    if (state_q == MUL) begin
      doneHi = prodFix[2*DATA_W-1:DATA_W];
      doneLo = prodFix[DATA_W-1:0];
    end else if (divZero_q) begin
      doneHi = dividend_q;
      doneLo = '1;
    end else begin
      doneHi = remFix;
      doneLo = quoFix;
    end
  end

  // Next-state and output-register logic. Flush beats completion, which
  // beats a new accept (none can happen while busy anyway), which beats
  // MEM simply draining the current output.
  always_comb begin
    state_d    = state_q;    cnt_d      = cnt_q;
    accHi_d    = accHi_q;    accLo_d    = accLo_q;    opMag_d   = opMag_q;
    dividend_d = dividend_q; resNeg_d   = resNeg_q;   remNeg_d  = remNeg_q;
    divZero_d  = divZero_q;  hi_d       = hi_q;       lo_d      = lo_q;
    outValid_d = outValid_q; instr_d    = instr_q;    pc_d      = pc_q;
    aluRes_d   = aluRes_q;   memData_d  = memData_q;  wreg_d    = wreg_q;
    aluCtl_d   = aluCtl_q;   regWrite_d = regWrite_q; memRead_d = memRead_q;
    memWrite_d = memWrite_q;

    if (busy) begin
      cnt_d   = cnt_q + CNT_W'(1);
      accHi_d = stepHi;
      accLo_d = stepLo;
    end

    if (Flush) begin
      outValid_d = 1'b0;
      state_d    = IDLE;
    end else if (lastIter) begin
      state_d    = IDLE;
      outValid_d = 1'b1;
      hi_d       = doneHi;
      lo_d       = doneLo;
      aluRes_d   = doneLo;
    end else if (accept) begin
      instr_d    = Instr_IN;
      pc_d       = Instr_PC_IN;
      wreg_d     = WriteRegister_IN;
      memData_d  = MemWriteData_IN;
      aluCtl_d   = ALU_Control_IN;
      regWrite_d = RegWrite_IN;
      memRead_d  = MemRead_IN;
      memWrite_d = MemWrite_IN;
      aluRes_d   = ALU_result_forward;
      outValid_d = !startsLong;
      if (startsLong) begin
        state_d    = isDivOp ? DIV : MUL;
        cnt_d      = '0;
        accHi_d    = '0;
        accLo_d    = magA;
        opMag_d    = magB;
        dividend_d = opA;
        resNeg_d   = signA ^ signB;
        remNeg_d   = signA;
        divZero_d  = (opB == '0);
      end
      if (fastMul) begin
        hi_d = fastProd[2*DATA_W-1:DATA_W];
        lo_d = fastProd[DATA_W-1:0];
      end
      if (ALU_Control_IN == OP_MTHI) hi_d = opA;
      if (ALU_Control_IN == OP_MTLO) lo_d = opA;
    end else if (outValid_q && out_ready) begin
      outValid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;  cnt_q      <= '0;
      accHi_q    <= '0;    accLo_q    <= '0;   opMag_q   <= '0;
      dividend_q <= '0;    resNeg_q   <= 1'b0; remNeg_q  <= 1'b0;
      divZero_q  <= 1'b0;  hi_q       <= '0;   lo_q      <= '0;
      outValid_q <= 1'b0;  instr_q    <= '0;   pc_q      <= '0;
      aluRes_q   <= '0;    memData_q  <= '0;   wreg_q    <= '0;
      aluCtl_q   <= '0;    regWrite_q <= 1'b0; memRead_q <= 1'b0;
      memWrite_q <= 1'b0;
    end else begin
      state_q    <= state_d;    cnt_q      <= cnt_d;
      accHi_q    <= accHi_d;    accLo_q    <= accLo_d;    opMag_q   <= opMag_d;
      dividend_q <= dividend_d; resNeg_q   <= resNeg_d;   remNeg_q  <= remNeg_d;
      divZero_q  <= divZero_d;  hi_q       <= hi_d;       lo_q      <= lo_d;
      outValid_q <= outValid_d; instr_q    <= instr_d;    pc_q      <= pc_d;
      aluRes_q   <= aluRes_d;   memData_q  <= memData_d;  wreg_q    <= wreg_d;
      aluCtl_q   <= aluCtl_d;   regWrite_q <= regWrite_d; memRead_q <= memRead_d;
      memWrite_q <= memWrite_d;
    end
  end

  assign out_valid         = outValid_q;
  assign Instr_OUT         = instr_q;
  assign Instr_PC_OUT      = pc_q;
  assign ALU_result_OUT    = aluRes_q;
  assign WriteRegister_OUT = wreg_q;
  assign MemWriteData_OUT  = memData_q;
  assign RegWrite_OUT      = regWrite_q;
  assign ALU_Control_OUT   = aluCtl_q;
  assign MemRead_OUT       = memRead_q;
  assign MemWrite_OUT      = memWrite_q;
  assign HI_OUT            = hi_q;
  assign LO_OUT            = lo_q;

endmodule

// File: tb/tb_exe_stage_mc.sv
// tb_exe_stage_mc: self-checking bench for exe_stage_mc with two bypass
// slots, so select code 3 is out of range. Honours EXE_FAST_MUL_EN.
module tb_exe_stage_mc;

  localparam int DW = 32;
  localparam int NF = 2;
  localparam int SW = 2;
`ifdef EXE_FAST_MUL_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = DW;
`endif

  logic           CLK, RESET, Flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0]    Instr_IN, Instr_PC_IN, Instr_OUT, Instr_PC_OUT;
  logic [DW-1:0]  OperandA_IN, OperandB_IN, MemWriteData_IN, MemWriteData_OUT;
  logic [SW-1:0]  RegA_Select, RegB_Select;
  logic [NF*DW-1:0] Fwd_Data_IN;
  logic [4:0]     WriteRegister_IN, WriteRegister_OUT, ShiftAmount_IN;
  logic           RegWrite_IN, MemRead_IN, MemWrite_IN, RegWrite_OUT, MemRead_OUT, MemWrite_OUT;
  logic [5:0]     ALU_Control_IN, ALU_Control_OUT;
  logic [DW-1:0]  ALU_result_OUT, ALU_result_forward, HI_OUT, LO_OUT;

  int checks, errors;
  logic [DW-1:0] hiM, loM;

  exe_stage_mc #(.DATA_W(DW), .NUM_FWD(NF), .SEL_W(SW)) dut (
    .CLK(CLK), .RESET(RESET), .Flush(Flush), .in_valid(in_valid), .in_ready(in_ready),
    .Instr_IN(Instr_IN), .Instr_PC_IN(Instr_PC_IN), .OperandA_IN(OperandA_IN),
    .OperandB_IN(OperandB_IN), .RegA_Select(RegA_Select), .RegB_Select(RegB_Select),
    .Fwd_Data_IN(Fwd_Data_IN), .WriteRegister_IN(WriteRegister_IN), .RegWrite_IN(RegWrite_IN),
    .MemRead_IN(MemRead_IN), .MemWrite_IN(MemWrite_IN), .MemWriteData_IN(MemWriteData_IN),
    .ALU_Control_IN(ALU_Control_IN), .ShiftAmount_IN(ShiftAmount_IN), .out_valid(out_valid),
    .out_ready(out_ready), .Instr_OUT(Instr_OUT), .Instr_PC_OUT(Instr_PC_OUT),
    .ALU_result_OUT(ALU_result_OUT), .WriteRegister_OUT(WriteRegister_OUT),
    .MemWriteData_OUT(MemWriteData_OUT), .RegWrite_OUT(RegWrite_OUT),
    .ALU_Control_OUT(ALU_Control_OUT), .MemRead_OUT(MemRead_OUT), .MemWrite_OUT(MemWrite_OUT),
    .ALU_result_forward(ALU_result_forward), .HI_OUT(HI_OUT), .LO_OUT(LO_OUT), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] modelAlu(input logic [5:0] op, input logic [31:0] a, b,
                                           input logic [4:0] sh, input logic [31:0] hi, lo);
    case (op)
      6'h00: return b << sh;
      6'h02: return b >> sh;
      6'h03: return 32'($signed(b) >>> sh);
      6'h10: return hi;
      6'h12: return lo;
      6'h20, 6'h21: return a + b;
      6'h22, 6'h23: return a - b;
      6'h24: return a & b;
      6'h25: return a | b;
      6'h26: return a ^ b;
      6'h27: return ~(a | b);
      6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'h2B: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] resolve(input logic [SW-1:0] sel, input logic [31:0] rf,
                                          input logic [NF*DW-1:0] fwd);
    int s;
    s = int'(sel);
    if (s >= 1 && s <= NF) return fwd[(s-1)*DW +: DW];
    return rf;
  endfunction

  task automatic modelMulDiv(input logic [5:0] op, input logic [31:0] a, b,
                             output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb, q, r, p;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = '0; lo = '0;
    case (op)
      6'h18: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      6'h19: begin u = {32'b0, a} * {32'b0, b}; hi = u[63:32]; lo = u[31:0]; end
      6'h1A: begin
        if (b == 0) begin hi = a; lo = '1; end
        else begin q = sa / sb; r = sa % sb; hi = r[31:0]; lo = q[31:0]; end
      end
      default: begin
        if (b == 0) begin hi = a; lo = '1; end
        else begin hi = a % b; lo = a / b; end
      end
    endcase
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idleInputs();
    Flush = 0; in_valid = 0; Instr_IN = 0; Instr_PC_IN = 0; OperandA_IN = 0; OperandB_IN = 0;
    RegA_Select = 0; RegB_Select = 0; Fwd_Data_IN = 0; WriteRegister_IN = 0; RegWrite_IN = 0;
    MemRead_IN = 0; MemWrite_IN = 0; MemWriteData_IN = 0; ALU_Control_IN = 0; ShiftAmount_IN = 0;
  endtask

  task automatic setOp(input logic [5:0] op, input logic [31:0] a, b, input logic [4:0] sh,
                       input logic [SW-1:0] sa, sb);
    in_valid = 1; ALU_Control_IN = op; OperandA_IN = a; OperandB_IN = b; ShiftAmount_IN = sh;
    RegA_Select = sa; RegB_Select = sb; Fwd_Data_IN = {$urandom, $urandom};
    Instr_IN = $urandom; Instr_PC_IN = $urandom; WriteRegister_IN = 5'($urandom);
    RegWrite_IN = 1'($urandom); MemRead_IN = 1'($urandom); MemWrite_IN = 1'($urandom);
    MemWriteData_IN = $urandom;
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    checks++;
    if ({out_valid, busy, HI_OUT, LO_OUT, ALU_result_OUT, Instr_OUT, Instr_PC_OUT, WriteRegister_OUT,
         MemWriteData_OUT, RegWrite_OUT, ALU_Control_OUT, MemRead_OUT, MemWrite_OUT} !== '0) begin
      errors++; $display("[TB] FAIL reset_outputs got nonzero value, want all zero");
    end
    @(negedge CLK); RESET = 1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b want 1", in_ready); end
  endtask

  task automatic test_add();
    logic [31:0] tag, pc, md; logic [4:0] wr; logic [2:0] ctl;
    setOp(6'h20, 32'd5, 32'd7, 5'd0, 2'd0, 2'd0);
    tag = Instr_IN; pc = Instr_PC_IN; md = MemWriteData_IN; wr = WriteRegister_IN;
    ctl = {RegWrite_IN, MemRead_IN, MemWrite_IN};
    #1;
    checks++;
    if (ALU_result_forward !== 32'h0000000C) begin
      errors++; $display("[TB] FAIL add_forward got %h want 0000000C", ALU_result_forward);
    end
    tick(); in_valid = 0;
    checks++;
    if (out_valid !== 1'b1 || ALU_result_OUT !== 32'h0000000C) begin
      errors++; $display("[TB] FAIL add_result got v=%b %h want v=1 0000000C", out_valid, ALU_result_OUT);
    end
    checks++;
    if ({Instr_OUT, Instr_PC_OUT, MemWriteData_OUT, WriteRegister_OUT, ALU_Control_OUT,
         RegWrite_OUT, MemRead_OUT, MemWrite_OUT} !== {tag, pc, md, wr, 6'h20, ctl}) begin
      errors++; $display("[TB] FAIL add_passthru got %h/%h/%h/%h want %h/%h/%h/%h",
                         Instr_OUT, Instr_PC_OUT, MemWriteData_OUT, WriteRegister_OUT, tag, pc, md, wr);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL add_clear got %b want 0", out_valid); end
  endtask

  task automatic test_forwarding();
    setOp(6'h21, 32'h5555, 32'd1, 5'd0, 2'd2, 2'd0);
    Fwd_Data_IN = {32'h00000100, 32'hDEADBEEF};
    #1;
    checks++;
    if (ALU_result_forward !== 32'h00000101) begin
      errors++; $display("[TB] FAIL fwd_slot1 got %h want 00000101", ALU_result_forward);
    end
    tick();
    checks++;
    if (ALU_result_OUT !== 32'h00000101) begin
      errors++; $display("[TB] FAIL fwd_slot1_out got %h want 00000101", ALU_result_OUT);
    end
    setOp(6'h20, 32'h1234, 32'h10, 5'd0, 2'd1, 2'd3);
    Fwd_Data_IN = {32'h77777777, 32'h00000020};
    tick(); in_valid = 0;
    checks++;
    if (ALU_result_OUT !== 32'h00000030) begin
      errors++; $display("[TB] FAIL fwd_out_of_range got %h want 00000030", ALU_result_OUT);
    end
    tick();
  endtask

  task automatic test_hilo();
    logic [31:0] x, y;
    x = $urandom; y = $urandom;
    setOp(6'h11, x, 32'd0, 5'd0, 2'd0, 2'd0); tick();
    checks++;
    if (HI_OUT !== x) begin errors++; $display("[TB] FAIL mthi got %h want %h", HI_OUT, x); end
    hiM = x;
    setOp(6'h13, y, 32'd0, 5'd0, 2'd0, 2'd0); tick();
    checks++;
    if (LO_OUT !== y || HI_OUT !== hiM) begin
      errors++; $display("[TB] FAIL mtlo got %h/%h want %h/%h", HI_OUT, LO_OUT, hiM, y);
    end
    loM = y;
    setOp(6'h10, $urandom, $urandom, 5'd0, 2'd0, 2'd0); tick();
    checks++;
    if (ALU_result_OUT !== hiM) begin errors++; $display("[TB] FAIL mfhi got %h want %h", ALU_result_OUT, hiM); end
    setOp(6'h12, $urandom, $urandom, 5'd0, 2'd0, 2'd0); tick(); in_valid = 0;
    checks++;
    if (ALU_result_OUT !== loM) begin errors++; $display("[TB] FAIL mflo got %h want %h", ALU_result_OUT, loM); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [0:17];
    logic [31:0] exp;
    ops = '{6'h00, 6'h02, 6'h03, 6'h10, 6'h12, 6'h20, 6'h21, 6'h22, 6'h23,
            6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h3F, 6'h05, 6'h2A};
    for (int i = 0; i < 60; i++) begin
      setOp(ops[$urandom_range(0, 17)], $urandom, $urandom, 5'($urandom),
            SW'($urandom), SW'($urandom));
      exp = modelAlu(ALU_Control_IN, resolve(RegA_Select, OperandA_IN, Fwd_Data_IN),
                     resolve(RegB_Select, OperandB_IN, Fwd_Data_IN), ShiftAmount_IN, hiM, loM);
      #1;
      checks++;
      if (in_ready !== 1'b1 || ALU_result_forward !== exp) begin
        errors++; $display("[TB] FAIL b2b_forward op=%h got %h rdy=%b want %h rdy=1",
                           ALU_Control_IN, ALU_result_forward, in_ready, exp);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || ALU_result_OUT !== exp) begin
        errors++; $display("[TB] FAIL b2b_result op=%h got v=%b %h want v=1 %h",
                           ALU_Control_OUT, out_valid, ALU_result_OUT, exp);
      end
    end
    in_valid = 0;
    tick();
  endtask

  task automatic test_mult();
    logic [5:0] op; logic [31:0] a, b, eh, el; int cyc, leak;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin op = 6'h18; a = 32'hFFFFFFFF; b = 32'h00000003; end
      else begin op = ($urandom_range(0, 1) != 0) ? 6'h18 : 6'h19; a = $urandom; b = $urandom; end
      modelMulDiv(op, a, b, eh, el);
      setOp(op, a, b, 5'd0, 2'd0, 2'd0);
      tick(); in_valid = 0;
      cyc = 0; leak = 0;
      while (!out_valid && cyc < 200) begin
        if (in_ready || !busy) leak++;
        tick(); cyc++;
      end
      checks++;
      if (cyc !== MUL_LAT) begin errors++; $display("[TB] FAIL mult_latency got %0d want %0d", cyc, MUL_LAT); end
      checks++;
      if (leak !== 0) begin errors++; $display("[TB] FAIL mult_stall got %0d ready cycles want 0", leak); end
      checks++;
      if (HI_OUT !== eh || LO_OUT !== el || ALU_result_OUT !== el) begin
        errors++; $display("[TB] FAIL mult_result op=%h got %h:%h r=%h want %h:%h", op, HI_OUT, LO_OUT,
                           ALU_result_OUT, eh, el);
      end
      checks++;
      if (busy !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("[TB] FAIL mult_idle got busy=%b rdy=%b want 0/1", busy, in_ready);
      end
      hiM = eh; loM = el;
      tick();
    end
  endtask

  task automatic test_div();
    logic [5:0] op; logic [31:0] a, b, eh, el; int cyc, leak;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin op = 6'h1A; a = 32'hFFFFFFF9; b = 32'h00000002; end
      else if (i == 1) begin op = 6'h1B; a = 32'h00000009; b = 32'h0; end
      else if (i == 2) begin op = 6'h1A; a = 32'h80000005; b = 32'h0; end
      else begin
        op = ($urandom_range(0, 1) != 0) ? 6'h1A : 6'h1B; a = $urandom;
        b = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(1, 1000)) : $urandom;
        if ($urandom_range(0, 1) != 0) b = -b;
      end
      modelMulDiv(op, a, b, eh, el);
      setOp(op, a, b, 5'd0, 2'd0, 2'd0);
      tick(); in_valid = 0;
      cyc = 0; leak = 0;
      while (!out_valid && cyc < 200) begin
        if (in_ready || !busy) leak++;
        tick(); cyc++;
      end
      checks++;
      if (cyc !== DW || leak !== 0) begin
        errors++; $display("[TB] FAIL div_latency got %0d leak=%0d want %0d leak=0", cyc, leak, DW);
      end
      checks++;
      if (HI_OUT !== eh || LO_OUT !== el || ALU_result_OUT !== el) begin
        errors++; $display("[TB] FAIL div_result op=%h %h/%h got %h:%h want %h:%h", op, a, b,
                           HI_OUT, LO_OUT, eh, el);
      end
      hiM = eh; loM = el;
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] tag;
    out_ready = 0;
    setOp(6'h20, 32'd10, 32'd20, 5'd0, 2'd0, 2'd0);
    tick();
    tag = Instr_OUT;
    checks++;
    if (out_valid !== 1'b1 || ALU_result_OUT !== 32'd30) begin
      errors++; $display("[TB] FAIL bp_first got v=%b %h want v=1 0000001e", out_valid, ALU_result_OUT);
    end
    setOp(6'h22, 32'd50, 32'd8, 5'd0, 2'd0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready got %b want 0", in_ready); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || ALU_result_OUT !== 32'd30 || Instr_OUT !== tag) begin
        errors++; $display("[TB] FAIL bp_hold got v=%b %h tag=%h want v=1 0000001e tag=%h",
                           out_valid, ALU_result_OUT, Instr_OUT, tag);
      end
    end
    out_ready = 1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release got %b want 1", in_ready); end
    tick(); in_valid = 0;
    checks++;
    if (out_valid !== 1'b1 || ALU_result_OUT !== 32'd42) begin
      errors++; $display("[TB] FAIL bp_second got v=%b %h want v=1 0000002a", out_valid, ALU_result_OUT);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_drain got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    setOp(6'h1B, $urandom, 32'd7, 5'd0, 2'd0, 2'd0);
    tick(); in_valid = 0;
    repeat (9) tick();
    Flush = 1; tick(); Flush = 0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || HI_OUT !== hiM || LO_OUT !== loM) begin
      errors++; $display("[TB] FAIL flush_abort got busy=%b v=%b %h:%h want 0/0 %h:%h",
                         busy, out_valid, HI_OUT, LO_OUT, hiM, loM);
    end
    repeat (40) tick();
    checks++;
    if (out_valid !== 1'b0 || HI_OUT !== hiM || LO_OUT !== loM || in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL flush_no_write got v=%b %h:%h rdy=%b want 0 %h:%h 1",
                         out_valid, HI_OUT, LO_OUT, in_ready, hiM, loM);
    end
    setOp(6'h11, 32'hABCD0123, 32'd0, 5'd0, 2'd0, 2'd0);
    Flush = 1; tick(); Flush = 0; in_valid = 0;
    checks++;
    if (out_valid !== 1'b0 || HI_OUT !== hiM) begin
      errors++; $display("[TB] FAIL flush_vs_accept got v=%b hi=%h want 0 %h", out_valid, HI_OUT, hiM);
    end
    tick();
  endtask

  task automatic test_reset_mid_op();
    setOp(6'h18, $urandom | 32'h1, $urandom | 32'h1, 5'd0, 2'd0, 2'd0);
    tick(); in_valid = 0;
    repeat (5) tick();
    #3 RESET = 0;
    #1;
    checks++;
    if ({out_valid, busy, HI_OUT, LO_OUT, ALU_result_OUT, Instr_OUT} !== '0) begin
      errors++; $display("[TB] FAIL reset_mid_op got v=%b b=%b %h:%h r=%h want all zero",
                         out_valid, busy, HI_OUT, LO_OUT, ALU_result_OUT);
    end
    @(posedge CLK); #3 RESET = 1;
    hiM = 0; loM = 0;
    repeat (40) tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || HI_OUT !== 32'd0 || LO_OUT !== 32'd0) begin
      errors++; $display("[TB] FAIL reset_no_resume got v=%b b=%b %h:%h want 0/0 0:0",
                         out_valid, busy, HI_OUT, LO_OUT);
    end
  endtask

  initial begin
    checks = 0; errors = 0; hiM = 0; loM = 0;
    idleInputs();
    RESET = 0; out_ready = 1;
    test_reset();
    test_add();
    test_forwarding();
    test_hilo();
    test_back_to_back();
    test_mult();
    test_div();
    test_backpressure();
    test_flush();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
